// File: rtl/multdiv_pkg.sv
// Shared widths, FSM state encoding and op select for the iterative mult/div unit.
package multdiv_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;
endpackage

// File: rtl/multdiv_seq_if.sv
// Request/result bundle between the control unit (master) and the mult/div unit (slave).
interface multdiv_seq_if;
    import multdiv_pkg::*;

    logic             start;
    logic             MultOrDiv;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             ErroDiv;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (output start, MultOrDiv, A, B,
                    input  busy, done, ErroDiv, Hi, Lo);
    modport slave  (input  start, MultOrDiv, A, B,
                    output busy, done, ErroDiv, Hi, Lo);
endinterface

// File: rtl/multdiv_dp.sv
// Booth multiply / restoring divide working registers and Hi/Lo; one iteration per step.
// No handshake of its own: load/step/fix are sequenced by multdiv_seq.
module multdiv_dp
    import multdiv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_fix,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    logic             r_op;
    logic [WIDTH:0]   r_m;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_booth_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_trial;

    // |-2^31| wraps to 0x80000000, which is the correct unsigned magnitude
    assign w_abs_a = i_a[WIDTH-1] ? -i_a : i_a;
    assign w_abs_b = i_b[WIDTH-1] ? -i_b : i_b;

    always_comb begin
        w_booth_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_booth_sum = r_acc + r_m;
            2'b10:   w_booth_sum = r_acc - r_m;
            default: w_booth_sum = r_acc;
        endcase
    end

    assign w_div_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_div_trial = w_div_shift - r_m;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op    <= OP_MULT;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (i_load) begin
                r_op  <= i_op;
                r_acc <= '0;
                r_qm1 <= 1'b0;
                if (i_op == OP_MULT) begin
                    r_m     <= {i_a[WIDTH-1], i_a};
                    r_q     <= i_b;
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                end else begin
                    r_m     <= {1'b0, w_abs_b};
                    r_q     <= w_abs_a;
                    r_neg_q <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                    r_neg_r <= i_a[WIDTH-1];
                end
            end else if (i_step) begin
                if (r_op == OP_MULT) begin
                    r_acc <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
                    r_q   <= {w_booth_sum[0], r_q[WIDTH-1:1]};
                    r_qm1 <= r_q[0];
                end else if (w_div_trial[WIDTH]) begin
                    r_acc <= w_div_shift;
                    r_q   <= {r_q[WIDTH-2:0], 1'b0};
                end else begin
                    r_acc <= w_div_trial;
                    r_q   <= {r_q[WIDTH-2:0], 1'b1};
                end
            end

            if (i_fix) begin
                if (r_op == OP_MULT) begin
                    r_hi <= r_acc[WIDTH-1:0];
                    r_lo <= r_q;
                end else begin
                    r_hi <= r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                    r_lo <= r_neg_q ? -r_q : r_q;
                end
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;
endmodule

// File: rtl/multdiv_seq.sv
// Sequencer for the signed mult/div unit: done 33 edges after start (next cycle on div-by-zero).
// No backpressure; start is only honoured in IDLE and otherwise dropped.
module multdiv_seq
    import multdiv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    multdiv_seq_if.slave  bus
);
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             r_busy;
    logic             r_done;
    logic             r_errodiv;

    logic             w_div_zero;
    logic             w_load;
    logic             w_step;
    logic             w_fix;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    assign w_div_zero = (bus.MultOrDiv == OP_DIV) && (bus.B == '0);
    assign w_load     = (r_state == IDLE) && bus.start && !w_div_zero;
    assign w_step     = (r_state == RUN);
    assign w_fix      = (r_state == FIX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_errodiv <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_errodiv <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (w_div_zero) begin
                            // Divide-by-zero skips the iterations and leaves Hi/Lo untouched
                            r_state   <= DONE;
                            r_err     <= 1'b1;
                            r_done    <= 1'b1;
                            r_errodiv <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_cnt   <= '0;
                            r_err   <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1))
                        r_state <= FIX;
                end
                FIX: begin
                    r_state   <= DONE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_errodiv <= r_err;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    multdiv_dp u_dp (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_step (w_step),
        .i_fix  (w_fix),
        .i_op   (bus.MultOrDiv),
        .i_a    (bus.A),
        .i_b    (bus.B),
        .o_hi   (w_hi),
        .o_lo   (w_lo)
    );

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.ErroDiv = r_errodiv;
    assign bus.Hi      = w_hi;
    assign bus.Lo      = w_lo;
endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed vector table, random ops against an
// arithmetic reference model, and hand-written sequences for ignore/abort/back-to-back.
module tb_multdiv_seq;
    import multdiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multdiv_seq_if bus ();

    multdiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: 64-bit signed product, truncating signed division; errors keep Hi/Lo
    task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic ee);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ee = 1'b0;
        if (op == OP_MULT) begin
            p = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (b == 32'd0) begin
            ee = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            m_hi = r[31:0];
            m_lo = q[31:0];
        end
        eh = m_hi;
        el = m_lo;
    endtask

    task automatic wait_done(output int k);
        k = -1;
        for (int i = 0; i < 80; i++) begin
            if (bus.done) begin
                k = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output logic err,
                          output int lat, output int busy_n, output logic done_after);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.MultOrDiv = op;
        bus.A         = a;
        bus.B         = b;
        @(negedge clk);
        // Scramble the request lines: the unit must have latched them already
        bus.start     = 1'b0;
        bus.MultOrDiv = ~op;
        bus.A         = $urandom;
        bus.B         = $urandom;
        lat    = -1;
        busy_n = 0;
        for (int k = 0; k < 80; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_n++;
            @(negedge clk);
        end
        hi  = bus.Hi;
        lo  = bus.Lo;
        err = bus.ErroDiv;
        @(negedge clk);
        done_after = bus.done;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] hi, lo, eh, el;
        logic        err, ee, da;
        int          lat, bn, k;
        logic        op;
        logic [31:0] a, b;
        int          dseen;

        tbl[0] = '{OP_MULT, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[1] = '{OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
        tbl[2] = '{OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[3] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[4] = '{OP_DIV,  32'd100,        32'd7,          32'd2,         32'd14,        1'b0};
        tbl[5] = '{OP_MULT, 32'd3,          32'd5,          32'd0,         32'd15,        1'b0};
        tbl[6] = '{OP_DIV,  32'd5,          32'd0,          32'd0,         32'd15,        1'b1};
        tbl[7] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        tbl[8] = '{OP_DIV,  32'd0,          32'd7,          32'd0,         32'd0,         1'b0};
        tbl[9] = '{OP_MULT, 32'd0,          32'h8000_0000, 32'd0,         32'd0,         1'b0};

        bus.start     = 1'b0;
        bus.MultOrDiv = OP_MULT;
        bus.A         = '0;
        bus.B         = '0;
        reset         = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err",  bus.ErroDiv, 0);
        chk("rst_hi",   bus.Hi, 0);
        chk("rst_lo",   bus.Lo, 0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, hi, lo, err, lat, bn, da);
            model(tbl[i].op, tbl[i].a, tbl[i].b, eh, el, ee);
            chk($sformatf("vec%0d_hi", i), hi, tbl[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, tbl[i].lo);
            chk($sformatf("vec%0d_err", i), err, tbl[i].err);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].err ? 0 : 33);
            chk($sformatf("vec%0d_busy", i), bn, tbl[i].err ? 0 : 33);
            chk($sformatf("vec%0d_pulse", i), da, 0);
        end

        for (int i = 0; i < 30; i++) begin
            op = 1'($urandom % 2);
            a  = pick();
            b  = ($urandom % 6 == 0) ? 32'd0 : pick();
            run_op(op, a, b, hi, lo, err, lat, bn, da);
            model(op, a, b, eh, el, ee);
            chk($sformatf("rnd%0d_hi", i), hi, eh);
            chk($sformatf("rnd%0d_lo", i), lo, el);
            chk($sformatf("rnd%0d_err", i), err, ee);
            chk($sformatf("rnd%0d_lat", i), lat, ee ? 0 : 33);
        end

        // Second start mid-run is dropped
        @(negedge clk);
        bus.start = 1'b1; bus.MultOrDiv = OP_MULT; bus.A = 32'd9; bus.B = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.A = 32'd123; bus.B = 32'd456;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(k);
        model(OP_MULT, 32'd9, 32'd9, eh, el, ee);
        chk("ign_lat", k + 5, 33);
        chk("ign_lo", bus.Lo, 32'd81);
        chk("ign_hi", bus.Hi, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("ign_noq_busy", bus.busy, 0);

        // Reset mid-operation aborts with cleared results
        bus.start = 1'b1; bus.A = 32'h1234; bus.B = 32'h5678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_hi", bus.Hi, 0);
        chk("abort_lo", bus.Lo, 0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        dseen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dseen++;
        end
        chk("abort_nodone", dseen, 0);
        chk("abort_lo_hold", bus.Lo, 0);
        run_op(OP_MULT, 32'hFFFF_FFFB, 32'd6, hi, lo, err, lat, bn, da);
        model(OP_MULT, 32'hFFFF_FFFB, 32'd6, eh, el, ee);
        chk("post_rst_hi", hi, eh);
        chk("post_rst_lo", lo, el);
        chk("post_rst_lat", lat, 33);

        // start held high: one op per IDLE visit, back-to-back launch after DONE
        @(negedge clk);
        bus.start = 1'b1; bus.MultOrDiv = OP_DIV; bus.A = 32'd1000; bus.B = 32'hFFFF_FFF9;
        @(negedge clk);
        wait_done(k);
        model(OP_DIV, 32'd1000, 32'hFFFF_FFF9, eh, el, ee);
        chk("hold_lat", k, 33);
        chk("hold_lo", bus.Lo, el);
        chk("hold_hi", bus.Hi, eh);
        @(negedge clk);
        chk("hold_idle_done", bus.done, 0);
        chk("hold_idle_busy", bus.busy, 0);
        bus.A = 32'd50; bus.B = 32'd3;
        @(negedge clk);
        chk("hold_relaunch", bus.busy, 1);
        bus.start = 1'b0;
        wait_done(k);
        model(OP_DIV, 32'd50, 32'd3, eh, el, ee);
        chk("hold2_lat", k, 33);
        chk("hold2_lo", bus.Lo, el);
        chk("hold2_hi", bus.Hi, eh);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
Iterative signed multiply/divide unit with its sequencing FSM, serving MULT and DIV for the main control unit.
- Accepts a one-cycle start pulse with operands and a MultOrDiv select.
- Runs a fixed 32-iteration radix-2 Booth multiply or restoring divide.
- Loads the Hi/Lo result registers, then pulses done.
- Division by zero is detected at start and reported on ErroDiv without iterating.

Parameters:
WIDTH, 32, operand and Hi/Lo width
CNT_W, 5, iteration counter width (log2 WIDTH)

Ports:
clk        input   1      system clock
reset      input   1      asynchronous, active-low reset
start      input   1      one-cycle request pulse; sampled only in IDLE
MultOrDiv  input   1      0 = MULT, 1 = DIV; sampled with start
A          input   WIDTH  multiplicand / dividend (signed), sampled with start
B          input   WIDTH  multiplier / divisor (signed), sampled with start
busy       output  1      high in RUN and FIX
done       output  1      one-cycle completion pulse
ErroDiv    output  1      one-cycle pulse, coincident with done, on divide-by-zero
Hi         output  WIDTH  MULT: product[63:32]; DIV: remainder
Lo         output  WIDTH  MULT: product[31:0]; DIV: quotient

Behaviour:
- Reset and clocking: clk is the single clock. reset is asynchronous and active-low. While reset = 0, everything clears immediately:
  - outputs: busy = 0, done = 0, ErroDiv = 0, Hi = 0, Lo = 0;
  - internal: FSM = IDLE, counter = 0, working registers = 0.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE, start = 1 at edge E0:
  - MULT, or DIV with B != 0: latch operands and op, clear the counter, go to RUN.
  - DIV with B == 0: go to DONE with err flag set. Hi/Lo are not written.
- RUN: one iteration per edge, E1..E32; the counter increments each iteration. At the iteration where counter == 31, go to FIX.
- FIX (edge E33): write Hi/Lo (MULT: copy; DIV: sign correction), go to DONE.
- DONE: done = 1 for exactly one cycle, and ErroDiv = err. Go to IDLE on the next edge.
- Latency:
  - normal op: done is high in the cycle after E33 (33 edges after the start sample);
  - div-by-zero: done is high in the cycle after E0.
- busy = 1 exactly in RUN and FIX. It is 0 in IDLE and DONE.
- MULT datapath:
  - Booth product register is {P_hi[WIDTH:0] (33 bits), P_lo[WIDTH-1:0], q_-1}. The multiplicand is sign-extended to 33 bits.
  - Per iteration, act on pair {P_lo[0], q_-1}: 01 → P_hi += M; 10 → P_hi -= M; 00/11 → no-op. Then arithmetic-shift the whole register right by 1.
  - 33-bit accumulation makes -2^31 × -2^31 = 2^62 exact.
  - FIX writes Hi = P_hi[31:0], Lo = P_lo.
- DIV datapath:
  - Restoring unsigned division on |A|, |B|. Each iteration shifts remainder:quotient left 1, trial-subtracts |B|, and restores if negative.
  - FIX applies MIPS truncation semantics: quotient negated if sign(A) != sign(B); remainder takes the sign of A.
  - Overflow case 0x80000000 / 0xFFFFFFFF yields Lo = 0x80000000, Hi = 0 (natural wrap, no error).
- Hi/Lo hold their values until the next FIX. An errored divide leaves them unchanged.
- Boundary conditions:
  - start while RUN, FIX or DONE is ignored, with no queuing.
  - MultOrDiv, A and B changing after E0 have no effect.
  - reset asserted mid-operation aborts immediately. No done is produced, and Hi/Lo read 0.
  - start held high for several cycles: one op per IDLE visit. A still-high start in the cycle after DONE launches a new op.
  - Operands of 0 are valid for MULT and for the DIV dividend (0/x gives Hi = Lo = 0).

Decomposition:
- Package multdiv_pkg:
  - WIDTH;
  - state encoding constants IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3;
  - op select constants OP_MULT = 1'b0, OP_DIV = 1'b1.
- Sub-module multdiv_dp:
  - holds the Booth and restoring-divide working registers and the per-iteration step logic;
  - control inputs: load, step, fix, op;
  - drives the Hi/Lo registers.
- multdiv_seq contains the FSM, counter, err flag and the done/busy/ErroDiv generation.

Test Plan:
1. MULT A = 7, B = 0xFFFFFFFD (-3):
   - busy high for exactly 33 cycles;
   - then done pulses once with Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB.
2. MULT A = B = 0x7FFFFFFF gives Hi = 0x3FFFFFFF, Lo = 0x00000001. MULT A = B = 0x80000000 gives Hi = 0x40000000, Lo = 0.
3. DIV A = 0xFFFFFFF9 (-7), B = 2 gives Lo = 0xFFFFFFFD (-3), Hi = 0xFFFFFFFF (-1). DIV A = 100, B = 7 gives Lo = 14, Hi = 2.
4. First MULT 3 × 5 (Hi = 0, Lo = 15), then DIV A = 5, B = 0:
   - done and ErroDiv both high in the cycle after the start edge;
   - busy never rises;
   - Hi = 0, Lo = 15 unchanged.
5. DIV A = 0x80000000, B = 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0, ErroDiv = 0.
6. Start MULT 9 × 9:
   - a second start with different operands at iteration 5 is ignored (result Lo = 81);
   - a new MULT, with reset driven low at iteration 10, gives busy = 0, done never pulses, Hi = Lo = 0;
   - a following start after reset release completes normally.
